// File: rtl/kv_defines_pkg.sv
// rtl/kv_defines_pkg.sv - state encoding and pad constant for the KV message-block sequencer
package kv_defines_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RW       = 3'd1,
      ST_PAD      = 3'd2,
      ST_ZERO     = 3'd3,
      ST_BLK_WAIT = 3'd4,
      ST_LENGTH   = 3'd5,
      ST_DONE     = 3'd6
   } kv_mblk_state_e;

   localparam logic [31:0] KV_PAD_WORD = 32'h8000_0000;

endpackage

// File: rtl/kv_mblk_fsm.sv
// rtl/kv_mblk_fsm.sv - message-block sequencer: copies data dwords into hash blocks and appends SHA padding
// Block offset and global data count are kept as separate counters.
module kv_mblk_fsm
   import kv_defines_pkg::*;
#(
   parameter  int BLOCK_BITS  = 512,
   parameter  int LEN_BITS    = 64,
   parameter  int PREFIX_BITS = 0,
   parameter  int MAX_DW      = 48,
   localparam int BLOCK_DW    = BLOCK_BITS / 32,
   localparam int LEN_DW      = LEN_BITS / 32,
   localparam int OFF_W       = $clog2(BLOCK_DW),
   localparam int CNT_W       = $clog2(MAX_DW + 1)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             zeroize,
   input  logic             start,
   input  logic             allow,
   input  logic             pad_en,
   input  logic             last,
   input  logic [CNT_W-1:0] num_dwords,
   input  logic             wr_ready,
   input  logic             blk_ready,
   output logic [CNT_W-1:0] read_offset,
   output logic             write_en,
   output logic [OFF_W-1:0] write_offset,
   output logic             write_pad,
   output logic [31:0]      pad_data,
   output logic             block_last,
   output logic             write_last,
   output logic             ready,
   output logic             done,
   output logic             error
);

   localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(BLOCK_DW - 1);
   localparam logic [OFF_W-1:0] OFF_ZEND  = OFF_W'(BLOCK_DW - LEN_DW - 1);
   localparam logic [CNT_W-1:0] CNT_MAXM1 = CNT_W'(MAX_DW - 1);

   kv_mblk_state_e   r_state, r_pend;
   logic [OFF_W-1:0] r_off;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_len;
   logic             r_err;

   kv_mblk_state_e   w_next, w_pend_nx;
   logic [OFF_W-1:0] w_off_nx, w_off_p1;
   logic [CNT_W-1:0] w_cnt_nx, w_cnt_p1;
   logic [31:0]      w_len_nx, w_len_calc;
   logic             w_err_nx;
   logic             w_at_last, w_rw_end, w_rw_err;

   assign w_off_p1    = r_off + OFF_W'(1);
   assign w_cnt_p1    = r_cnt + CNT_W'(1);
   assign w_at_last   = (r_off == OFF_LAST);
   assign w_len_calc  = ((32'(r_cnt) + 32'd1) << 5) + 32'(PREFIX_BITS);
   assign read_offset = r_cnt;
   assign write_offset = r_off;

   // Unpadded requests end on last or on the requested count; hitting MAX_DW otherwise is an overrun.
   assign w_rw_end = !pad_en && (last || (w_cnt_p1 == num_dwords));
   assign w_rw_err = !w_rw_end && !last && (r_cnt == CNT_MAXM1);

   always_comb begin
      w_next     = r_state;
      w_pend_nx  = r_pend;
      w_off_nx   = r_off;
      w_cnt_nx   = r_cnt;
      w_len_nx   = r_len;
      w_err_nx   = r_err;
      ready      = 1'b0;
      write_en   = 1'b0;
      write_pad  = 1'b0;
      pad_data   = '0;
      block_last = 1'b0;
      write_last = 1'b0;
      done       = 1'b0;
      error      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) begin
               w_off_nx = '0;
               w_cnt_nx = '0;
               w_len_nx = '0;
               w_err_nx = 1'b0;
               w_next   = allow ? ST_RW : ST_DONE;
            end
         end

         ST_RW: begin
            write_en   = 1'b1;
            block_last = w_at_last;
            write_last = w_rw_end || w_rw_err;
            if (wr_ready) begin
               w_off_nx = w_off_p1;
               w_cnt_nx = w_cnt_p1;
               if (w_rw_end || w_rw_err) begin
                  w_err_nx = w_rw_err;
                  w_next   = ST_DONE;
               end else if (last) begin
                  w_len_nx = w_len_calc;
                  if (w_at_last) begin
                     w_pend_nx = ST_PAD;
                     w_next    = ST_BLK_WAIT;
                  end else begin
                     w_next = ST_PAD;
                  end
               end else if (w_at_last) begin
                  w_pend_nx = ST_RW;
                  w_next    = ST_BLK_WAIT;
               end
            end
         end

         ST_PAD: begin
            write_en   = 1'b1;
            write_pad  = 1'b1;
            pad_data   = KV_PAD_WORD;
            block_last = w_at_last;
            if (wr_ready) begin
               w_off_nx = w_off_p1;
               if (r_off == OFF_ZEND) begin
                  w_next = ST_LENGTH;
               end else if (w_at_last) begin
                  w_pend_nx = ST_ZERO;
                  w_next    = ST_BLK_WAIT;
               end else begin
                  w_next = ST_ZERO;
               end
            end
         end

         // A pad word past the length slot lands above OFF_ZEND, so the fill wraps through OFF_LAST first.
         ST_ZERO: begin
            write_en   = 1'b1;
            write_pad  = 1'b1;
            block_last = w_at_last;
            if (wr_ready) begin
               w_off_nx = w_off_p1;
               if (r_off == OFF_ZEND) begin
                  w_next = ST_LENGTH;
               end else if (w_at_last) begin
                  w_pend_nx = ST_ZERO;
                  w_next    = ST_BLK_WAIT;
               end
            end
         end

         ST_BLK_WAIT: begin
            if (blk_ready) begin
               w_next = r_pend;
            end
         end

         ST_LENGTH: begin
            write_en   = 1'b1;
            write_pad  = 1'b1;
            pad_data   = w_at_last ? r_len : 32'd0;
            block_last = w_at_last;
            write_last = w_at_last;
            if (wr_ready) begin
               w_off_nx = w_off_p1;
               if (w_at_last) begin
                  w_err_nx = 1'b0;
                  w_next   = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            done   = 1'b1;
            error  = r_err;
            w_next = ST_IDLE;
         end

         default: begin
            w_next = ST_IDLE;
         end
      endcase

      if (zeroize) begin
         w_next   = ST_IDLE;
         w_off_nx = '0;
         w_cnt_nx = '0;
         w_len_nx = '0;
         w_err_nx = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= ST_IDLE;
         r_pend  <= ST_RW;
         r_off   <= '0;
         r_cnt   <= '0;
         r_len   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_pend  <= w_pend_nx;
         r_off   <= w_off_nx;
         r_cnt   <= w_cnt_nx;
         r_len   <= w_len_nx;
         r_err   <= w_err_nx;
      end
   end

endmodule

// File: tb/tb_kv_mblk_fsm.sv
// tb/tb_kv_mblk_fsm.sv - scoreboard bench for kv_mblk_fsm (512-bit blocks, 64-bit length field)
module tb_kv_mblk_fsm;

   localparam int CNT_W = 6;
   localparam int OFF_W = 4;

   logic             clk = 1'b0;
   logic             rst_b = 1'b0;
   logic             zeroize = 1'b0, start = 1'b0, allow = 1'b0, pad_en = 1'b0, last = 1'b0;
   logic [CNT_W-1:0] num_dwords = '0;
   logic             wr_ready = 1'b0, blk_ready = 1'b0;

   logic [CNT_W-1:0] read_offset, p_read_offset;
   logic [OFF_W-1:0] write_offset, p_write_offset;
   logic [31:0]      pad_data, p_pad_data;
   logic             write_en, write_pad, block_last, write_last, ready, done, error;
   logic             p_write_en, p_write_pad, p_block_last, p_write_last, p_ready, p_done, p_error;

   kv_mblk_fsm u_dut (
      .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .start(start), .allow(allow),
      .pad_en(pad_en), .last(last), .num_dwords(num_dwords), .wr_ready(wr_ready),
      .blk_ready(blk_ready), .read_offset(read_offset), .write_en(write_en),
      .write_offset(write_offset), .write_pad(write_pad), .pad_data(pad_data),
      .block_last(block_last), .write_last(write_last), .ready(ready), .done(done),
      .error(error)
   );

   kv_mblk_fsm #(.PREFIX_BITS(512)) u_dut_pfx (
      .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .start(start), .allow(allow),
      .pad_en(pad_en), .last(last), .num_dwords(num_dwords), .wr_ready(wr_ready),
      .blk_ready(blk_ready), .read_offset(p_read_offset), .write_en(p_write_en),
      .write_offset(p_write_offset), .write_pad(p_write_pad), .pad_data(p_pad_data),
      .block_last(p_block_last), .write_last(p_write_last), .ready(p_ready), .done(p_done),
      .error(p_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] off;
      logic [31:0] pad;
      logic [31:0] data;
      logic [31:0] bl;
      logic [31:0] wl;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_w(input int off, input bit pad, input logic [31:0] data, input bit bl, input bit wl);
      exp_t e;
      e.off  = off;
      e.pad  = {31'd0, pad};
      e.data = data;
      e.bl   = {31'd0, bl};
      e.wl   = {31'd0, wl};
      exp_q.push_back(e);
   endtask

   // Expected write stream: data dwords, then 0x80000000, zero fill to dword 14 mod 16, 64-bit bit length.
   task automatic push_model(input int n, input bit pe, input int num, input bit ul, output bit err);
      int nd;
      int p;
      err = 1'b0;
      if (!pe) begin
         nd = (ul && n < num) ? n : num;
      end else if (!ul || n > 48) begin
         nd  = 48;
         err = 1'b1;
      end else begin
         nd = n;
      end
      for (int i = 0; i < nd; i++)
         push_w(i % 16, 1'b0, i, (i % 16) == 15, (i == nd - 1) && (!pe || err));
      if (pe && !err) begin
         p = nd;
         push_w(p % 16, 1'b1, 32'h8000_0000, (p % 16) == 15, 1'b0);
         p++;
         while ((p % 16) != 14) begin
            push_w(p % 16, 1'b1, 32'd0, (p % 16) == 15, 1'b0);
            p++;
         end
         push_w(14, 1'b1, 32'd0, 1'b0, 1'b0);
         push_w(15, 1'b1, nd * 32, 1'b1, 1'b1);
      end
   endtask

   task automatic run_req(input int n, input bit pe, input int num, input bit ul,
                          input bit al, input bit stall, input bit zpad);
      bit   exp_err;
      int   dcnt;
      int   cyc;
      int   stall_left;
      bit   stalled_once;
      bit   got_done;
      bit   blk_prev;
      bit   wl_prev;
      exp_t e;
      dcnt = 0; cyc = 0; stall_left = 0; stalled_once = 0;
      got_done = 0; blk_prev = 0; wl_prev = 0; exp_err = 0;

      @(negedge clk); #1;
      chk("idle_ready", ready, 1);
      if (al) push_model(n, pe, num, ul, exp_err);
      pad_en     = pe;
      num_dwords = num[CNT_W-1:0];
      allow      = al;
      wr_ready   = 1'b1;
      blk_ready  = 1'b1;
      last       = 1'b0;
      start      = 1'b1;

      while (!got_done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (stall && !stalled_once && dcnt == 5) begin
            stall_left   = 3;
            stalled_once = 1;
         end
         wr_ready  = (stall_left == 0);
         last      = ul && (dcnt == n - 1);
         blk_ready = !blk_prev;
         #1;
         if (wl_prev) chk("done_next", done, 1);
         wl_prev = 0;
         if (blk_prev) begin
            chk("blkwait_we", write_en, 0);
            chk("blkwait_off", write_offset, 0);
         end
         blk_prev = 0;
         if (stall_left > 0) begin
            stall_left--;
            if (exp_q.size() > 0) begin
               chk("hold_off", write_offset, exp_q[0].off);
               chk("hold_rd", read_offset, exp_q[0].data);
            end
         end
         if (zpad && write_pad) begin
            zeroize = 1'b1;
            @(negedge clk);
            zeroize = 1'b0;
            #1;
            chk("zero_ready", ready, 1);
            chk("zero_we", write_en, 0);
            chk("zero_rdoff", read_offset, 0);
            exp_q.delete();
            return;
         end
         if (write_en && wr_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexp_wr", write_offset, 32'hdead);
            end else begin
               e = exp_q.pop_front();
               chk("off", write_offset, e.off);
               chk("wpad", write_pad, e.pad);
               chk("data", e.pad[0] ? pad_data : 32'(read_offset), e.data);
               chk("blast", block_last, e.bl);
               chk("wlast", write_last, e.wl);
               if (e.pad[0] && e.wl[0]) chk("pfx_len", p_pad_data, e.data + 32'd512);
            end
            if (!write_pad) dcnt++;
            if (block_last && !write_last) blk_prev = 1;
            if (write_last) wl_prev = 1;
         end
         if (done) begin
            got_done = 1;
            chk("err", error, exp_err);
            chk("q_empty", exp_q.size(), 0);
         end
      end
      if (!got_done) chk("timeout", 0, 1);
      exp_q.delete();
      wr_ready = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_we", write_en, 0);
      chk("rst_done", done, 0);
      chk("rst_rdoff", read_offset, 0);
      chk("rst_wroff", write_offset, 0);
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_ready", ready, 1);

      run_req(12, 1, 0, 1, 1, 0, 0);
      run_req(14, 1, 0, 1, 1, 0, 0);
      run_req(16, 1, 0, 1, 1, 0, 0);
      run_req(13, 1, 0, 1, 1, 0, 0);
      run_req(12, 0, 12, 0, 1, 1, 0);
      run_req(8, 0, 20, 1, 1, 0, 0);
      run_req(4, 1, 0, 1, 0, 0, 0);
      run_req(49, 1, 0, 0, 1, 0, 0);
      run_req(5, 1, 0, 1, 1, 0, 1);
      run_req(1, 1, 0, 1, 1, 0, 0);
      for (int k = 0; k < 4; k++)
         run_req($urandom_range(1, 40), 1, 0, 1, 1, $urandom_range(0, 1) == 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
